// File: rtl/bus_ctrl.sv
// bus_ctrl: memory-mapped bus controller between an OPC-family CPU and up to
// NSLAVES peripherals. Priority-decodes the CPU address against per-region
// base/mask pairs, drives active-low chip selects, muxes slave read data back
// to the CPU and stretches accesses by a per-region wait count via clken.
//
// Optional feature macro: BUS_TIMEOUT_EN (ready handshake + timeout/bus_err).
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   address/rnw/req   CPU access (req = vda|vpa)
//   clken             CPU clock enable (low while an access is stretched)
//   cpu_din           read data to CPU (all ones on miss/idle/timeout)
//   cs_b              per-slave chip select, active low
//   wr_stb            one-cycle write strobe on the completing cycle
//   slave_dout        packed slave read data, slave i at [i*DSIZE +: DSIZE]
//   slave_ready       per-slave ready (BUS_TIMEOUT_EN only)
//   miss              current access hits no region
//   bus_err, err_clr  sticky timeout flag and its synchronous clear
module bus_ctrl #(
    parameter int unsigned ASIZE   = 20,
    parameter int unsigned DSIZE   = 32,
    parameter int unsigned NSLAVES = 2,
    parameter int unsigned WBITS   = 4,
    parameter logic [NSLAVES*ASIZE-1:0] BASE  = {20'h00000, 20'h0FE08},
    parameter logic [NSLAVES*ASIZE-1:0] MASK  = {20'h0C000, 20'h0FFFE},
    parameter logic [NSLAVES*WBITS-1:0] WAITS = {4'd1, 4'd0},
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ASIZE-1:0]         address,
    input  logic                     rnw,
    input  logic                     req,
    output logic                     clken,
    output logic [DSIZE-1:0]         cpu_din,
    output logic [NSLAVES-1:0]       cs_b,
    output logic                     wr_stb,
    input  logic [NSLAVES*DSIZE-1:0] slave_dout,
    input  logic [NSLAVES-1:0]       slave_ready,
    output logic                     miss,
    output logic                     bus_err,
    input  logic                     err_clr
);

    // Elaboration-time parameter range checks
    if (NSLAVES < 1 || NSLAVES > 8) begin : g_bad_nslaves
        $error("bus_ctrl: NSLAVES must be 1..8");
    end
    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("bus_ctrl: TIMEOUT must be 2..65535");
    end

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t             state, state_nxt;
    logic [WBITS-1:0]   cnt, cnt_nxt;

    logic               hit;
    logic [NSLAVES-1:0] win_sel;
    logic [DSIZE-1:0]   win_dout;
    logic [WBITS-1:0]   win_w;
    logic               ready_c;
    logic               timeout_c;
    logic               done_c;

    // Priority decode: iterate high to low so the lowest hitting index wins
    always_comb begin
        hit      = 1'b0;
        win_sel  = '0;
        win_dout = '1;
        win_w    = '0;
        for (int i = int'(NSLAVES) - 1; i >= 0; i--) begin
            if ((address & MASK[i*ASIZE +: ASIZE]) == BASE[i*ASIZE +: ASIZE]) begin
                hit        = 1'b1;
                win_sel    = '0;
                win_sel[i] = 1'b1;
                win_dout   = slave_dout[i*DSIZE +: DSIZE];
                win_w      = WAITS[i*WBITS +: WBITS];
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] tcnt, tcnt_nxt;

    assign ready_c   = |(slave_ready & win_sel);
    // Cycle k of an access sees tcnt = k-1, so this fires on cycle TIMEOUT
    assign timeout_c = (state == S_WAIT) && !((cnt == '0) && ready_c) && (tcnt >= TO_LAST);

    always_comb begin
        tcnt_nxt = tcnt;
        if (state == S_IDLE) begin
            tcnt_nxt = (req && hit && (win_w != '0)) ? 16'd1 : 16'd0;
        end else if (done_c) begin
            tcnt_nxt = 16'd0;
        end else if (tcnt != 16'hFFFF) begin
            tcnt_nxt = tcnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tcnt <= 16'd0;
        else       tcnt <= tcnt_nxt;
    end

    // Sticky error: a timeout in the same cycle beats err_clr
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          bus_err <= 1'b0;
        else if (timeout_c) bus_err <= 1'b1;
        else if (err_clr)   bus_err <= 1'b0;
    end
`else
    logic unused_inputs;

    assign unused_inputs = ^{slave_ready, err_clr};
    assign ready_c       = 1'b1;
    assign timeout_c     = 1'b0;
    assign bus_err       = 1'b0;
`endif

    assign done_c = ((cnt == '0) && ready_c) || timeout_c;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and wait counter
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (req && hit && (win_w != '0)) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = win_w - WBITS'(1);
                end
            end
            S_WAIT: begin
                if (cnt != '0) cnt_nxt = cnt - WBITS'(1);
                if (done_c) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Combinational CPU/slave-side outputs; reset forces the idle bus view
    always_comb begin
        clken   = 1'b1;
        cs_b    = '1;
        cpu_din = '1;
        miss    = 1'b0;
        wr_stb  = 1'b0;
        if (!reset) begin
            miss = req && !hit;
            if (req && hit) begin
                cs_b    = ~win_sel;
                cpu_din = win_dout;
            end
            case (state)
                S_IDLE:  if (req && hit && (win_w != '0)) clken = 1'b0;
                S_WAIT:  if (!done_c) clken = 1'b0;
                default: clken = 1'b1;
            endcase
            if (timeout_c) cpu_din = '1;
            wr_stb = req && !rnw && clken && hit && !timeout_c;
        end
    end

endmodule

// File: tb/tb_bus_ctrl.sv
// Directed self-checking bench for bus_ctrl with default region map:
// region 0 = 0x0FE08/0x0FFFE (0 waits), region 1 = 0x00000/0x0C000 (1 wait).
module tb_bus_ctrl;

    localparam int unsigned ASIZE   = 20;
    localparam int unsigned DSIZE   = 32;
    localparam int unsigned NSLAVES = 2;

    localparam logic [31:0] D0 = 32'hAAAA_0000;
    localparam logic [31:0] D1 = 32'hBBBB_0001;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [ASIZE-1:0]         address;
    logic                     rnw;
    logic                     req;
    logic                     clken;
    logic [DSIZE-1:0]         cpu_din;
    logic [NSLAVES-1:0]       cs_b;
    logic                     wr_stb;
    logic [NSLAVES*DSIZE-1:0] slave_dout;
    logic [NSLAVES-1:0]       slave_ready;
    logic                     miss;
    logic                     bus_err;
    logic                     err_clr;

    int checks = 0;
    int errors = 0;

    bus_ctrl #(.TIMEOUT(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .rnw         (rnw),
        .req         (req),
        .clken       (clken),
        .cpu_din     (cpu_din),
        .cs_b        (cs_b),
        .wr_stb      (wr_stb),
        .slave_dout  (slave_dout),
        .slave_ready (slave_ready),
        .miss        (miss),
        .bus_err     (bus_err),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    // Move to just after the next rising edge; inputs change here
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b1; rnw = 1'b0; address = 20'h00100;
        #2;
        checks++; if (clken !== 1'b1) begin errors++; $display("FAIL reset_clken got %b exp 1", clken); end
        checks++; if (cs_b !== 2'b11) begin errors++; $display("FAIL reset_cs_b got %b exp 11", cs_b); end
        checks++; if (wr_stb !== 1'b0) begin errors++; $display("FAIL reset_wr_stb got %b exp 0", wr_stb); end
        checks++; if (miss !== 1'b0) begin errors++; $display("FAIL reset_miss got %b exp 0", miss); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err got %b exp 0", bus_err); end
        tick();
        reset = 1'b0; req = 1'b0;
        #1;
        checks++; if (cs_b !== 2'b11 || cpu_din !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL idle_bus got cs_b=%b din=%h exp 11/ffffffff", cs_b, cpu_din);
        end
    endtask

    task automatic test_region0_read();
        tick();
        req = 1'b1; rnw = 1'b1; address = 20'h0FE08;
        #1;
        checks++; if (cs_b !== 2'b10) begin errors++; $display("FAIL r0_cs_b got %b exp 10", cs_b); end
        checks++; if (clken !== 1'b1) begin errors++; $display("FAIL r0_clken got %b exp 1", clken); end
        checks++; if (cpu_din !== D0) begin errors++; $display("FAIL r0_din got %h exp %h", cpu_din, D0); end
        checks++; if (miss !== 1'b0) begin errors++; $display("FAIL r0_miss got %b exp 0", miss); end
        checks++; if (wr_stb !== 1'b0) begin errors++; $display("FAIL r0_wr_stb got %b exp 0", wr_stb); end
    endtask

    task automatic test_region1_read();
        tick();
        req = 1'b1; rnw = 1'b1; address = 20'h00100;
        #1;
        checks++; if (cs_b !== 2'b01) begin errors++; $display("FAIL r1_cs_b got %b exp 01", cs_b); end
        checks++; if (clken !== 1'b0) begin errors++; $display("FAIL r1_wait_clken got %b exp 0", clken); end
        tick();
        checks++; if (clken !== 1'b1) begin errors++; $display("FAIL r1_done_clken got %b exp 1", clken); end
        checks++; if (cs_b !== 2'b01) begin errors++; $display("FAIL r1_done_cs_b got %b exp 01", cs_b); end
        checks++; if (cpu_din !== D1) begin errors++; $display("FAIL r1_din got %h exp %h", cpu_din, D1); end
    endtask

    task automatic test_write();
        tick();
        req = 1'b1; rnw = 1'b0; address = 20'h00100;
        #1;
        checks++; if (clken !== 1'b0 || wr_stb !== 1'b0) begin
            errors++; $display("FAIL w1_wait got clken=%b wr_stb=%b exp 0/0", clken, wr_stb);
        end
        tick();
        checks++; if (clken !== 1'b1 || wr_stb !== 1'b1) begin
            errors++; $display("FAIL w1_done got clken=%b wr_stb=%b exp 1/1", clken, wr_stb);
        end
        // 0x0FE09 also matches region 0 under mask 0x0FFFE: zero-wait write
        tick();
        address = 20'h0FE09;
        #1;
        checks++; if (cs_b !== 2'b10 || wr_stb !== 1'b1 || clken !== 1'b1) begin
            errors++; $display("FAIL w0_alias got cs_b=%b wr_stb=%b clken=%b exp 10/1/1", cs_b, wr_stb, clken);
        end
        tick();
        req = 1'b0;
        #1;
        checks++; if (wr_stb !== 1'b0) begin errors++; $display("FAIL w_idle_stb got %b exp 0", wr_stb); end
    endtask

    task automatic test_miss();
        tick();
        req = 1'b1; rnw = 1'b0; address = 20'h08000;
        #1;
        checks++; if (miss !== 1'b1) begin errors++; $display("FAIL miss_flag got %b exp 1", miss); end
        checks++; if (cs_b !== 2'b11) begin errors++; $display("FAIL miss_cs_b got %b exp 11", cs_b); end
        checks++; if (cpu_din !== 32'hFFFF_FFFF) begin errors++; $display("FAIL miss_din got %h exp ffffffff", cpu_din); end
        checks++; if (clken !== 1'b1 || wr_stb !== 1'b0) begin
            errors++; $display("FAIL miss_ctl got clken=%b wr_stb=%b exp 1/0", clken, wr_stb);
        end
    endtask

    task automatic test_back_to_back();
        tick();
        req = 1'b1; rnw = 1'b1; address = 20'h00200;
        #1;
        checks++; if (clken !== 1'b0) begin errors++; $display("FAIL b2b_a_wait got %b exp 0", clken); end
        tick();
        checks++; if (clken !== 1'b1) begin errors++; $display("FAIL b2b_a_done got %b exp 1", clken); end
        // Next cycle is a fresh region-1 access: waits again, no dead cycle
        tick();
        address = 20'h00300;
        #1;
        checks++; if (clken !== 1'b0 || cs_b !== 2'b01) begin
            errors++; $display("FAIL b2b_b_wait got clken=%b cs_b=%b exp 0/01", clken, cs_b);
        end
        tick();
        checks++; if (clken !== 1'b1 || cpu_din !== D1) begin
            errors++; $display("FAIL b2b_b_done got clken=%b din=%h exp 1/%h", clken, cpu_din, D1);
        end
        tick();
        address = 20'h0FE08;
        #1;
        checks++; if (clken !== 1'b1 || cpu_din !== D0) begin
            errors++; $display("FAIL b2b_c got clken=%b din=%h exp 1/%h", clken, cpu_din, D0);
        end
    endtask

    task automatic test_reset_in_wait();
        tick();
        req = 1'b1; rnw = 1'b0; address = 20'h00100;
        #1;
        checks++; if (clken !== 1'b0) begin errors++; $display("FAIL rw_wait got %b exp 0", clken); end
        tick();
        // Now in the completing WAIT cycle; reset must kill the strobe
        reset = 1'b1;
        #1;
        checks++; if (clken !== 1'b1 || cs_b !== 2'b11 || wr_stb !== 1'b0) begin
            errors++; $display("FAIL rw_abort got clken=%b cs_b=%b wr_stb=%b exp 1/11/0", clken, cs_b, wr_stb);
        end
        tick();
        checks++; if (wr_stb !== 1'b0) begin errors++; $display("FAIL rw_hold_stb got %b exp 0", wr_stb); end
        reset = 1'b0; req = 1'b0;
        tick();
        req = 1'b1; rnw = 1'b1; address = 20'h00100;
        #1;
        checks++; if (clken !== 1'b0) begin errors++; $display("FAIL rw_after_wait got %b exp 0", clken); end
        tick();
        checks++; if (clken !== 1'b1 || cpu_din !== D1) begin
            errors++; $display("FAIL rw_after_done got clken=%b din=%h exp 1/%h", clken, cpu_din, D1);
        end
        tick();
        req = 1'b0;
    endtask

`ifdef BUS_TIMEOUT_EN
    task automatic test_timeout();
        tick();
        slave_ready = 2'b01;
        req = 1'b1; rnw = 1'b0; address = 20'h00100;
        for (int k = 1; k <= 7; k++) begin
            #1;
            checks++; if (clken !== 1'b0) begin errors++; $display("FAIL to_wait_%0d got %b exp 0", k, clken); end
            tick();
        end
        #1;
        checks++; if (clken !== 1'b1 || cpu_din !== 32'hFFFF_FFFF || wr_stb !== 1'b0) begin
            errors++; $display("FAIL to_force got clken=%b din=%h wr_stb=%b exp 1/ffffffff/0", clken, cpu_din, wr_stb);
        end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL to_err_early got %b exp 0", bus_err); end
        tick();
        req = 1'b0; slave_ready = 2'b11;
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL to_err_set got %b exp 1", bus_err); end
        tick(); tick();
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL to_err_hold got %b exp 1", bus_err); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL to_err_clr got %b exp 0", bus_err); end
    endtask
`else
    task automatic test_timeout();
        tick();
        slave_ready = 2'b00; err_clr = 1'b1;
        req = 1'b1; rnw = 1'b1; address = 20'h00100;
        #1;
        checks++; if (clken !== 1'b0) begin errors++; $display("FAIL nr_wait got %b exp 0", clken); end
        tick();
        checks++; if (clken !== 1'b1 || cpu_din !== D1) begin
            errors++; $display("FAIL nr_done got clken=%b din=%h exp 1/%h", clken, cpu_din, D1);
        end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL nr_bus_err got %b exp 0", bus_err); end
        tick();
        req = 1'b0; slave_ready = 2'b11; err_clr = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b0; address = '0; rnw = 1'b1; req = 1'b0; err_clr = 1'b0;
        slave_dout = {D1, D0};
        slave_ready = 2'b11;
        test_reset();
        test_region0_read();
        test_region1_read();
        test_write();
        test_miss();
        test_back_to_back();
        test_reset_in_wait();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_ctrl.md
# bus_ctrl

Parametrised memory-mapped bus controller between an OPC-family CPU and up to NSLAVES peripherals. Decodes the CPU address against per-region base/mask pairs, drives one active-low chip select per slave, and multiplexes slave read data back to the CPU. It stretches each access by a per-region wait-state count by deasserting the CPU `clken`. Unlike a fixed decode-and-mux, it adds programmable wait states, priority decode over N regions, a miss flag and an optional ready/timeout mechanism.

## Interface
Parameters:
- `ASIZE`, 20: address width.
- `DSIZE`, 32: data width.
- `NSLAVES`, 2: number of regions/slaves, 1..8.
- `WBITS`, 4: wait-count width.
- `BASE`, {20'h00000, 20'h0FE08}: packed region bases, region i at `[i*ASIZE +: ASIZE]`.
- `MASK`, {20'h0C000, 20'h0FFFE}: packed region masks, same packing.
- `WAITS`, {4'd1, 4'd0}: packed per-region wait states, region i at `[i*WBITS +: WBITS]`.
- `TIMEOUT`, 64: ready timeout in cycles, 2..65535. Used only with BUS_TIMEOUT_EN.

Ports:
- `clk`, in, 1: single system clock, all state on rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `address`, in, ASIZE: CPU address.
- `rnw`, in, 1: CPU read-not-write.
- `req`, in, 1: CPU access valid (vda|vpa).
- `clken`, out, 1: CPU clock enable.
- `cpu_din`, out, DSIZE: read data to CPU.
- `cs_b`, out, NSLAVES: per-slave chip select, active low.
- `wr_stb`, out, 1: one-cycle write strobe on the completing cycle.
- `slave_dout`, in, NSLAVES*DSIZE: packed slave read data.
- `slave_ready`, in, NSLAVES: per-slave ready.
- `miss`, out, 1: current access hits no region.
- `bus_err`, out, 1: sticky timeout flag.
- `err_clr`, in, 1: synchronous clear of `bus_err`.

## Operation
- Hit decode: region i hits when `(address & MASK_i) == BASE_i`. The lowest hitting index wins. Decode is combinational and relies on the CPU holding the address while `clken`=0.
- `cs_b[i]`=0 only for the winning region while `req`=1, for every cycle of the access including waits. All other bits are 1.
- `cpu_din` is `slave_dout` of the winner. On a miss or with `req`=0 it is all ones.
- `miss`=`req` & no hit. A miss completes in zero waits.
- FSM states:
  - IDLE: on `req` & hit & W>0, `clken`=0, load `cnt`=W-1, go to WAIT. Otherwise `clken`=1.
  - WAIT: if `cnt`≠0, decrement `cnt`, `clken`=0. If `cnt`=0 and ready, `clken`=1, go to IDLE.
- `wr_stb`=`req` & !`rnw` & `clken` & hit. It asserts exactly once per write.
- Reset, asynchronous: state=IDLE, `cnt`=0, timeout counter=0, `bus_err`=0.
  - While `reset`=1: `clken`=1, `cs_b`=all ones, `wr_stb`=0, `miss`=0.
  - Reset in WAIT aborts the access. No strobe is issued.
- Wait counts are 0..2^WBITS-1. The counter never wraps below 0.

## Timing
- Access starting in cycle N with W waits: `clken` is low in cycles N..N+W-1 and high in N+W. The CPU samples `cpu_din` at the end of N+W.
- Back-to-back accesses: the cycle after completion is evaluated as a fresh IDLE access. There is no dead cycle.
- `clken`, `cs_b`, `cpu_din`, `miss` and `wr_stb` are combinational from inputs and state. `bus_err` is registered.

## Configuration
- `BUS_TIMEOUT_EN` defined:
  - WAIT completion additionally requires `slave_ready[winner]`=1.
  - A 16-bit counter increments on every cycle of the access. If it reaches TIMEOUT with ready low, the access is forced complete: `clken`=1, `cpu_din` all ones, `wr_stb` suppressed, `bus_err` set on the next edge.
  - `err_clr` clears `bus_err` unless a timeout occurs in the same cycle (set wins).
- `BUS_TIMEOUT_EN` undefined:
  - `slave_ready` and `err_clr` are ignored.
  - `bus_err` is constant 0.
  - Completion depends on the wait count only.

## Test plan
- Defaults, read `address`=0x0FE08 with `req`=1 → `cs_b`=2'b10, `clken` high the same cycle, `cpu_din`=`slave_dout[31:0]`, `miss`=0.
- Read at 0x00100 (region 1, W=1) → `cs_b`=2'b01, `clken` 0 for 1 cycle then 1, `cpu_din`=`slave_dout[63:32]` on the completing cycle.
- Write at 0x00100 → `wr_stb` high exactly one cycle, coincident with `clken`=1. Address 0x0FE09 → region 0 wins (0x0FE09 & 0x0FFFE = 0x0FE08).
- Address 0x08000 → `miss`=1, `cs_b`=2'b11, `cpu_din`=0xFFFFFFFF, `clken`=1.
- Assert `reset` during region-1 WAIT → `clken`=1 and `cs_b`=2'b11 immediately, no `wr_stb`. After release the next access behaves normally.
- With BUS_TIMEOUT_EN, TIMEOUT=8, `slave_ready[1]`=0 → `clken` high on cycle 8 of the access, `cpu_din`=all ones, `bus_err`=1 next edge and held until `err_clr`=1.
